// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant, serial bus and slave-select lines shared by the masters and bus_arbiter.
// The arbiter connects through the slave modport; the master modport is the requesters' view.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int SLAVE_SEL_BITS = 2
);
    localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int NSL = 1 << SLAVE_SEL_BITS;

    logic [NUM_MASTERS-1:0] m_bus_req;
    logic [NUM_MASTERS-1:0] m_addr_tx;
    logic [NUM_MASTERS-1:0] m_data_tx;
    logic [NUM_MASTERS-1:0] m_valid;
    logic [NUM_MASTERS-1:0] m_bus_ready;
    logic                   bus_addr;
    logic                   bus_data;
    logic                   bus_valid;
    logic [NSL-1:0]         slave_sel;
    logic [IDW-1:0]         grant_id;
    logic                   bus_busy;

    modport master (
        output m_bus_req, m_addr_tx, m_data_tx, m_valid,
        input  m_bus_ready, bus_addr, bus_data, bus_valid, slave_sel, grant_id, bus_busy
    );

    modport slave (
        input  m_bus_req, m_addr_tx, m_data_tx, m_valid,
        output m_bus_ready, bus_addr, bus_data, bus_valid, slave_sel, grant_id, bus_busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared serial bus with leading-address slave decode.
// Optional grant timeout is compiled in when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int SLAVE_SEL_BITS = 2
`ifdef BUS_ARB_TIMEOUT_EN
    , parameter int TIMEOUT      = 64
`endif
) (
    input logic          clock,
    input logic          rstn,
    bus_arbiter_if.slave bus
);
    localparam int IDW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int NSL  = 1 << SLAVE_SEL_BITS;
    localparam int CNTW = $clog2(SLAVE_SEL_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACTIVE, S_RELEASE} state_t;

    state_t                  r_state;
    logic [NUM_MASTERS-1:0]  r_ready;
    logic [IDW-1:0]          r_grantId;
    logic [IDW-1:0]          r_last;
    logic                    r_busy;
    logic [NSL-1:0]          r_slaveSel;
    logic [SLAVE_SEL_BITS-1:0] r_selShift;
    logic [CNTW-1:0]         r_bitCnt;

    logic [IDW-1:0]          w_winner;
    logic [IDW-1:0]          w_scan;
    logic                    w_anyReq;
    logic                    w_reqGranted;
    logic                    w_validGranted;
    logic [SLAVE_SEL_BITS-1:0] w_selNext;
    logic                    w_timeout;

    // Scan from the master after r_last, wrapping; the nearest requester wins.
    always_comb begin
        w_winner = '0;
        w_anyReq = 1'b0;
        w_scan   = r_last;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_scan = (w_scan == IDW'(NUM_MASTERS - 1)) ? '0 : w_scan + IDW'(1);
            if (!w_anyReq && bus.m_bus_req[w_scan]) begin
                w_winner = w_scan;
                w_anyReq = 1'b1;
            end
        end
    end

    assign w_reqGranted   = |(r_ready & bus.m_bus_req);
    assign w_validGranted = |(r_ready & bus.m_valid);
    assign w_selNext      = (r_selShift << 1) | SLAVE_SEL_BITS'(bus.bus_addr);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] r_timer;

    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!rstn || r_state == S_IDLE) begin
            r_timer <= '0;
        end else if (r_state == S_GRANT || r_state == S_ACTIVE) begin
            r_timer <= r_timer + TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_ready    <= '0;
            r_grantId  <= '0;
            r_last     <= IDW'(NUM_MASTERS - 1);
            r_busy     <= 1'b0;
            r_slaveSel <= '0;
            r_selShift <= '0;
            r_bitCnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_ready    <= NUM_MASTERS'(1) << w_winner;
                        r_grantId  <= w_winner;
                        r_last     <= w_winner;
                        r_busy     <= 1'b1;
                        r_selShift <= '0;
                        r_bitCnt   <= '0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT, S_ACTIVE: begin
                    // Dropping the request (or timing out) wins over a decode finishing in the same cycle.
                    if (!w_reqGranted || w_timeout) begin
                        r_ready    <= '0;
                        r_slaveSel <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_RELEASE;
                    end else if (r_state == S_GRANT && w_validGranted) begin
                        r_selShift <= w_selNext;
                        r_bitCnt   <= r_bitCnt + CNTW'(1);
                        if (r_bitCnt == CNTW'(SLAVE_SEL_BITS - 1)) begin
                            r_slaveSel <= NSL'(1) << w_selNext;
                            r_state    <= S_ACTIVE;
                        end
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_bus_ready = r_ready;
    assign bus.bus_addr    = |(r_ready & bus.m_addr_tx);
    assign bus.bus_data    = |(r_ready & bus.m_data_tx);
    assign bus.bus_valid   = |(r_ready & bus.m_valid);
    assign bus.slave_sel   = r_slaveSel;
    assign bus.grant_id    = r_grantId;
    assign bus.bus_busy    = r_busy;
endmodule
